// File: rtl/if_pkg.sv
// Shared constants, entry type and address-error helper for the fetch queue.
// Optional feature macro: IFQ_ADEL_CHECK_EN (adds a per-entry address-error flag).
package if_pkg;

  localparam logic [31:0] RESET_PC_DEF = 32'h0000_3000;
  localparam logic [31:0] NOP_WORD_DEF = 32'h0000_0000;
  localparam logic [31:0] IM_LO        = 32'h0000_3000;
  localparam logic [31:0] IM_HI        = 32'h0000_6FFC;

`ifdef IFQ_ADEL_CHECK_EN
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        adel;
  } ifq_entry_t;
`else
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } ifq_entry_t;
`endif

  // Misaligned, or outside the instruction-memory window.
  function automatic logic addr_err(input logic [31:0] pc);
    return (pc[1:0] != 2'b00) || (pc < IM_LO) || (pc > IM_HI);
  endfunction

endpackage

// File: rtl/ifq_storage.sv
// DEPTH x ifq_entry_t register file: one synchronous write port, one asynchronous read port.
// Contents are deliberately not reset; validity is tracked by the controller.
module ifq_storage
  import if_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  ifq_entry_t        wdata,
  input  logic [AW-1:0]     raddr,
  output ifq_entry_t        rdata
);

  ifq_entry_t mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/if_fetch_queue.sv
// Fetch queue between the PC register and decode; in_ready doubles as the PC advance enable.
// Optional feature macro: IFQ_ADEL_CHECK_EN (adds out_adel and NOP substitution for bad pcs).
module if_fetch_queue
  import if_pkg::*;
#(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = RESET_PC_DEF,
  parameter logic [31:0] NOP_WORD = NOP_WORD_DEF
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   flush,
  input  logic [31:0]            pc_i,
  input  logic [31:0]            instr_i,
  input  logic                   in_valid,
  output logic                   in_ready,
  output logic [31:0]            out_pc,
  output logic [31:0]            out_instr,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [$clog2(DEPTH):0] count
`ifdef IFQ_ADEL_CHECK_EN
  ,
  output logic                   out_adel
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [AW-1:0] head;
  logic [AW-1:0] tail;
  logic          push;
  logic          pop;
  logic          show;
  ifq_entry_t    wr_entry;
  ifq_entry_t    rd_entry;

  // Reset forces the empty view immediately, not only after the edge.
  assign show      = (count != '0) && !reset;
  assign out_valid = show;
  assign in_ready  = reset || (count != FULL_CNT);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  always_comb begin
    wr_entry       = '0;
    wr_entry.pc    = pc_i;
    wr_entry.instr = instr_i;
`ifdef IFQ_ADEL_CHECK_EN
    wr_entry.adel  = addr_err(pc_i);
`endif
  end

  ifq_storage #(.DEPTH(DEPTH), .AW(AW)) u_storage (
    .clk   (clk),
    .we    (push && !flush && !reset),
    .waddr (tail),
    .wdata (wr_entry),
    .raddr (head),
    .rdata (rd_entry)
  );

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push) tail <= tail + 1'b1;
      if (pop)  head <= head + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign out_pc = show ? rd_entry.pc : RESET_PC;

`ifdef IFQ_ADEL_CHECK_EN
  assign out_adel  = show && rd_entry.adel;
  assign out_instr = (show && !rd_entry.adel) ? rd_entry.instr : NOP_WORD;
`else
  assign out_instr = show ? rd_entry.instr : NOP_WORD;
`endif

endmodule
